// File: rtl/nv_ram_rwsp_61x64_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsp_61x64_fifo_ctrl_pkg
// Shared constants, types and the RAM pointer wrap helper for the
// 61x64 two-port RAM FIFO controller and its skid buffer.
// -----------------------------------------------------------------------------
package nv_ram_rwsp_61x64_fifo_ctrl_pkg;

  localparam int unsigned DEPTH     = 61;  // RAM entries
  localparam int unsigned WIDTH     = 64;  // data width
  localparam int unsigned AW        = 6;   // RAM address width
  localparam int unsigned OUT_DEPTH = 3;   // skid entries plus in-flight read slots
  localparam int unsigned CW        = 7;   // occupancy counter width (holds 0..64)
  localparam int unsigned SW        = 2;   // skid count / pointer width (holds 0..3)
  localparam int unsigned UW        = 3;   // width of the output-side usage sum

  typedef logic [AW-1:0]    addr_t;
  typedef logic [WIDTH-1:0] data_t;
  typedef logic [CW-1:0]    cnt_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  // DEPTH is not a power of two, so the wrap is an explicit compare.
  function automatic addr_t ptr_inc(input addr_t n);
    return (n == LAST_ADDR) ? '0 : n + addr_t'(1);
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_61x64_fifo_ctrl_skid.sv
// -----------------------------------------------------------------------------
// nv_ram_fifo_ctrl_skid
// OUT_DEPTH-entry circular buffer that catches RAM read data as it lands and
// presents the oldest word to the consumer. Push and pop in the same cycle
// are both honoured. The caller guarantees no push when full and no pop when
// empty.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (clears pointers and count)
//   push_i       write push_data_i into the tail entry
//   push_data_i  data to store
//   pop_i        retire the head entry
//   cnt_o        number of valid entries (0..OUT_DEPTH)
//   head_o       oldest stored word (from the entry registers)
// -----------------------------------------------------------------------------
module nv_ram_fifo_ctrl_skid
  import nv_ram_rwsp_61x64_fifo_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  data_t         push_data_i,
  input  logic          pop_i,
  output logic [SW-1:0] cnt_o,
  output data_t         head_o
);

  data_t         mem_q [OUT_DEPTH];
  logic [SW-1:0] wp_q, wp_d;
  logic [SW-1:0] rp_q, rp_d;
  logic [SW-1:0] cnt_q, cnt_d;

  function automatic logic [SW-1:0] sk_inc(input logic [SW-1:0] p);
    return (p == SW'(OUT_DEPTH - 1)) ? '0 : p + SW'(1);
  endfunction

  always_comb begin
    wp_d  = push_i ? sk_inc(wp_q) : wp_q;
    rp_d  = pop_i  ? sk_inc(rp_q) : rp_q;
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + SW'(1);
      2'b01:   cnt_d = cnt_q - SW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Data entries carry no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wp_q] <= push_data_i;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[rp_q];

endmodule

// File: rtl/nv_ram_rwsp_61x64_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsp_61x64_fifo_ctrl
// Turns an external 61x64 two-port RAM with registered read (address latch
// re, output register ore) into a valid/ready FIFO. A 3-slot output skid
// buffer hides the 2-cycle read latency so both ends sustain 1 word/cycle.
// Total capacity is 61 RAM words plus 3 output slots.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wr_pvld/prdy/pd     producer handshake and data
//   rd_pvld/prdy/pd     consumer handshake and data
//   ram_we/wa/di        RAM write port
//   ram_re/ra           RAM read-address latch enable and address
//   ram_ore             RAM output-register enable
//   ram_dout            RAM registered read data
//   hwm_clr, hwm        only with NV_RAM_FIFO_CTRL_HWM_EN defined: sync clear
//                       and high-water mark of words held (occ + skid count)
// -----------------------------------------------------------------------------
module nv_ram_rwsp_61x64_fifo_ctrl
  import nv_ram_rwsp_61x64_fifo_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout
`ifdef NV_RAM_FIFO_CTRL_HWM_EN
  ,
  input  logic             hwm_clr,
  output logic [6:0]       hwm
`endif
);

  addr_t         wr_ptr_q, wr_ptr_d;
  addr_t         rd_ptr_q, rd_ptr_d;
  cnt_t          occ_q, occ_d;      // written, not yet captured into skid
  cnt_t          avail_q, avail_d;  // written, not yet read-issued
  logic          s1_vld_q;          // address latched, output register loading
  logic          s2_vld_q;          // ram_dout valid this cycle
  logic [SW-1:0] skid_cnt;
  logic [UW-1:0] used;
  logic [UW-1:0] used_after_pop;
  logic          wr_fire;
  logic          pop;
  logic          issue;

  // ---------------------------------------------------------------- write side
  assign wr_prdy = !rst && (occ_q < cnt_t'(DEPTH));
  assign wr_fire = wr_pvld && wr_prdy;
  assign ram_we  = wr_fire;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;

  // ---------------------------------------------------------------- read issue
  assign rd_pvld        = (skid_cnt != '0);
  assign pop            = rd_pvld && rd_prdy;
  assign used           = UW'(s1_vld_q) + UW'(s2_vld_q) + UW'(skid_cnt);
  // Counting a same-cycle pop as free space keeps the stream at 1 word/cycle;
  // pop implies skid_cnt > 0, so the subtraction cannot underflow.
  assign used_after_pop = used - UW'(pop);
  assign issue          = !rst && (avail_q != '0) && (used_after_pop < UW'(OUT_DEPTH));
  assign ram_re         = issue;
  assign ram_ra         = rd_ptr_q;
  assign ram_ore        = s1_vld_q;

  // ---------------------------------------------------------------- next state
  always_comb begin
    wr_ptr_d = wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = issue   ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    avail_d = avail_q;
    if (wr_fire && !issue) begin
      avail_d = avail_q + cnt_t'(1);
    end else if (!wr_fire && issue) begin
      avail_d = avail_q - cnt_t'(1);
    end

    // The RAM slot is freed only once its data is captured (s2), so the
    // writer can never overwrite an address whose read is still in flight.
    occ_d = occ_q;
    if (wr_fire && !s2_vld_q) begin
      occ_d = occ_q + cnt_t'(1);
    end else if (!wr_fire && s2_vld_q) begin
      occ_d = occ_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      avail_q  <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      avail_q  <= avail_d;
      s1_vld_q <= issue;
      s2_vld_q <= s1_vld_q;
    end
  end

  // ---------------------------------------------------------------- skid buffer
  nv_ram_fifo_ctrl_skid u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (s2_vld_q),
    .push_data_i (ram_dout),
    .pop_i       (pop),
    .cnt_o       (skid_cnt),
    .head_o      (rd_pd)
  );

`ifdef NV_RAM_FIFO_CTRL_HWM_EN
  // ---------------------------------------------------------------- high-water mark
  cnt_t held;
  cnt_t hwm_q, hwm_d;

  assign held = occ_q + cnt_t'(skid_cnt);

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = '0;
    end else if (held > hwm_q) begin
      hwm_d = held;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_61x64_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_nv_ram_rwsp_61x64_fifo_ctrl;

  localparam int DEPTH = 61;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_pvld = 1'b0;
  logic        wr_prdy;
  logic [63:0] wr_pd = '0;
  logic        rd_pvld;
  logic        rd_prdy = 1'b0;
  logic [63:0] rd_pd;
  logic        ram_we;
  logic [5:0]  ram_wa;
  logic [63:0] ram_di;
  logic        ram_re;
  logic [5:0]  ram_ra;
  logic        ram_ore;
  logic [63:0] ram_dout;

  always #5 clk = ~clk;

  nv_ram_rwsp_61x64_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .wr_pvld  (wr_pvld),
    .wr_prdy  (wr_prdy),
    .wr_pd    (wr_pd),
    .rd_pvld  (rd_pvld),
    .rd_prdy  (rd_prdy),
    .rd_pd    (rd_pd),
    .ram_we   (ram_we),
    .ram_wa   (ram_wa),
    .ram_di   (ram_di),
    .ram_re   (ram_re),
    .ram_ra   (ram_ra),
    .ram_ore  (ram_ore),
    .ram_dout (ram_dout)
  );

  // External RAM: write port, read-address latch, registered output.
  logic [63:0] ram_mem [DEPTH];
  logic [5:0]  ra_lat;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_di;
    if (ram_re) ra_lat <= ram_ra;
    if (ram_ore) ram_dout <= ram_mem[ra_lat];
  end

  // Scoreboard and occupancy model (RAM words not yet captured downstream).
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int occ_m    = 0;
  logic ore_prev = 1'b0;
  int re_cnt = 0;
  int pops   = 0;
  bit wr_wrap_seen = 0, rd_wrap_seen = 0;
  logic [5:0] last_wa = '0, last_ra = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      exp_q.delete();
      occ_m    = 0;
      ore_prev = 1'b0;
    end else begin
      n_checks++;
      if (wr_prdy !== (occ_m < DEPTH)) begin
        n_errors++;
        $display("FAIL wr_prdy_vs_occ: got %b want %b (occ %0d)", wr_prdy, (occ_m < DEPTH), occ_m);
      end
      if (wr_pvld && wr_prdy) begin
        exp_q.push_back(wr_pd);
        n_checks++;
        if (ram_wa > 6'd60) begin
          n_errors++;
          $display("FAIL ram_wa_range: got %0d want <=60", ram_wa);
        end
        if (last_wa == 6'd60 && ram_wa == 6'd0) wr_wrap_seen = 1;
        last_wa = ram_wa;
      end
      if (ram_re) begin
        re_cnt++;
        n_checks++;
        if (ram_ra > 6'd60) begin
          n_errors++;
          $display("FAIL ram_ra_range: got %0d want <=60", ram_ra);
        end
        if (last_ra == 6'd60 && ram_ra == 6'd0) rd_wrap_seen = 1;
        last_ra = ram_ra;
      end
      if (rd_pvld && rd_prdy) begin
        pops++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL pop_empty: got %h want no output", rd_pd);
        end else begin
          e = exp_q.pop_front();
          if (rd_pd !== e) begin
            n_errors++;
            $display("FAIL rd_data: got %h want %h", rd_pd, e);
          end
        end
      end
      occ_m = occ_m + ((wr_pvld && wr_prdy) ? 1 : 0) - (ore_prev ? 1 : 0);
      ore_prev = ram_ore;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int c;
    rd_prdy = 1'b1;
    wr_pvld = 1'b0;
    for (c = 0; c < 300 && exp_q.size() != 0; c++) tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || rd_pvld !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d left rd_pvld %b want 0 left rd_pvld 0", name, exp_q.size(), rd_pvld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (wr_prdy !== 1'b0) begin n_errors++; $display("FAIL reset_wr_prdy_in_rst: got %b want 0", wr_prdy); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_pvld, wr_prdy, ram_re, ram_ore, ram_we} !== 5'b01000) begin
      n_errors++;
      $display("FAIL reset_outputs: got pvld/prdy/re/ore/we %b want 01000", {rd_pvld, wr_prdy, ram_re, ram_ore, ram_we});
    end
    n_checks++;
    if (ram_wa !== 6'd0 || ram_ra !== 6'd0) begin
      n_errors++;
      $display("FAIL reset_addr: got wa %0d ra %0d want 0 0", ram_wa, ram_ra);
    end
    repeat (2) tick();
  endtask

  task automatic test_single();
    logic [63:0] d = 64'hA5A5_0000_0000_0001;
    rd_prdy = 1'b1;
    tick();
    wr_pvld = 1'b1;
    wr_pd   = d;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b1 || ram_wa !== 6'd0 || ram_di !== d) begin
      n_errors++;
      $display("FAIL single_write: got we %b wa %0d di %h want 1 0 %h", ram_we, ram_wa, ram_di, d);
    end
    tick();
    wr_pvld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rd_pvld !== (k == 4)) begin
        n_errors++;
        $display("FAIL single_latency_t%0d: got rd_pvld %b want %b", k, rd_pvld, (k == 4));
      end
      if (k == 1) begin
        n_checks++;
        if (ram_re !== 1'b1 || ram_ra !== 6'd0) begin
          n_errors++;
          $display("FAIL single_issue: got re %b ra %0d want 1 0", ram_re, ram_ra);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (ram_ore !== 1'b1) begin n_errors++; $display("FAIL single_ore: got %b want 1", ram_ore); end
      end
      if (k == 4) begin
        n_checks++;
        if (rd_pd !== d) begin n_errors++; $display("FAIL single_data: got %h want %h", rd_pd, d); end
      end else begin
        tick();
      end
    end
    drain("single");
  endtask

  task automatic test_fill();
    int acc = 0;
    int re0;
    int pops0;
    bit ok_now;
    rd_prdy = 1'b0;
    tick();
    re0   = re_cnt;
    pops0 = pops;
    wr_pvld = 1'b1;
    wr_pd   = 64'hF000_0000_0000_0000;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ok_now = wr_pvld && wr_prdy;
      tick();
      if (ok_now) begin
        acc++;
        if (acc < 70) wr_pd = 64'hF000_0000_0000_0000 | 64'(acc);
        else wr_pvld = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (acc !== 64) begin n_errors++; $display("FAIL fill_accepted: got %0d want 64", acc); end
    n_checks++;
    if (wr_prdy !== 1'b0) begin n_errors++; $display("FAIL fill_wr_prdy: got %b want 0", wr_prdy); end
    n_checks++;
    if (re_cnt - re0 !== 3 || ram_re !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_issue_stall: got %0d issues re %b want 3 0", re_cnt - re0, ram_re);
    end
    n_checks++;
    if (rd_pvld !== 1'b1 || rd_pd !== 64'hF000_0000_0000_0000) begin
      n_errors++;
      $display("FAIL fill_head: got pvld %b pd %h want 1 f000000000000000", rd_pvld, rd_pd);
    end
    drain("fill");
    n_checks++;
    if (pops - pops0 !== 64) begin n_errors++; $display("FAIL fill_pops: got %0d want 64", pops - pops0); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1, stalls = 0;
    bit ok_now;
    logic [63:0] base = 64'h5000_0000_0000_0000;
    rd_prdy = 1'b1;
    tick();
    wr_pvld = 1'b1;
    wr_pd   = base;
    for (int c = 0; c < 500 && got < 200; c++) begin
      @(negedge clk);
      ok_now = wr_pvld && wr_prdy;
      if (wr_pvld && !wr_prdy) stalls++;
      if (rd_pvld && rd_prdy) begin
        got++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
      if (ok_now) begin
        sent++;
        if (sent < 200) wr_pd = base + 64'(sent);
        else wr_pvld = 1'b0;
      end
    end
    n_checks++;
    if (got !== 200 || sent !== 200) begin
      n_errors++;
      $display("FAIL stream_count: got sent %0d recv %0d want 200 200", sent, got);
    end
    n_checks++;
    if (last - first + 1 !== 200 || first !== 4) begin
      n_errors++;
      $display("FAIL stream_rate: got span %0d first %0d want 200 4", last - first + 1, first);
    end
    n_checks++;
    if (stalls !== 0) begin n_errors++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
    n_checks++;
    if (!wr_wrap_seen || !rd_wrap_seen) begin
      n_errors++;
      $display("FAIL stream_wrap: got wr %0d rd %0d want 1 1", wr_wrap_seen, rd_wrap_seen);
    end
    drain("stream");
  endtask

  task automatic test_random();
    int full_hits = 0, max_held = 0;
    rd_prdy = 1'b0;
    tick();
    wr_pvld = 1'b1;
    for (int c = 0; c < 100; c++) begin
      wr_pd = {$urandom, $urandom};
      @(negedge clk);
      if (!wr_prdy) break;
      tick();
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      wr_pvld = ($urandom_range(0, 9) < 7);
      wr_pd   = {$urandom, $urandom};
      rd_prdy = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (!wr_prdy) full_hits++;
      if (exp_q.size() > max_held) max_held = exp_q.size();
    end
    n_checks++;
    if (full_hits == 0) begin n_errors++; $display("FAIL random_full_reached: got %0d want >0", full_hits); end
    n_checks++;
    if (max_held !== 64) begin n_errors++; $display("FAIL random_max_held: got %0d want 64", max_held); end
    tick();
    drain("random");
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bit ok_now;
    rd_prdy = 1'b0;
    tick();
    wr_pvld = 1'b1;
    wr_pd   = 64'hC000_0000_0000_0000;
    for (int c = 0; c < 40 && acc < 20; c++) begin
      @(negedge clk);
      ok_now = wr_pvld && wr_prdy;
      tick();
      if (ok_now) begin
        acc++;
        wr_pd = 64'hC000_0000_0000_0000 | 64'(acc);
      end
    end
    wr_pvld = 1'b0;
    repeat (4) tick();
    rd_prdy = 1'b1;
    repeat (2) tick();
    rd_prdy = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ram_ore !== 1'b1 || wr_prdy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_inflight: got ore %b prdy %b want 1 0", ram_ore, wr_prdy);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_pvld, ram_ore, ram_re, wr_prdy} !== 4'b0001) begin
      n_errors++;
      $display("FAIL midrst_after: got pvld/ore/re/prdy %b want 0001", {rd_pvld, ram_ore, ram_re, wr_prdy});
    end
    tick();
    wr_pvld = 1'b1;
    wr_pd   = 64'hD000_0000_0000_0000;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b1 || ram_wa !== 6'd0) begin
      n_errors++;
      $display("FAIL midrst_wa: got we %b wa %0d want 1 0", ram_we, ram_wa);
    end
    tick();
    wr_pd = 64'hD000_0000_0000_0001;
    @(negedge clk);
    n_checks++;
    if (ram_re !== 1'b1 || ram_ra !== 6'd0) begin
      n_errors++;
      $display("FAIL midrst_ra: got re %b ra %0d want 1 0", ram_re, ram_ra);
    end
    tick();
    wr_pd = 64'hD000_0000_0000_0002;
    tick();
    wr_pvld = 1'b0;
    drain("midrst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_empty: got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_61x64_fifo_ctrl.md
Name: nv_ram_rwsp_61x64_fifo_ctrl

Overview:
- Sequencer that turns the 61x64 two-port registered-read RAM into a valid/ready FIFO.
- Drives the RAM's write port, read-address latch (re) and output-register enable (ore).
- Hides the 2-cycle read latency with a small output skid buffer, giving 1 word/cycle at both ends.
- Sits between a producer and consumer inside an NVDLA sub-unit; the RAM instance is external, wired to the ram_* ports.

Parameters:
- DEPTH, 61, RAM entries.
- WIDTH, 64, data width.
- AW, 6, RAM address width.
- OUT_DEPTH, 3, skid-buffer entries plus in-flight read slots.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_pvld  in  1  producer valid.
- wr_prdy  out  1  producer ready.
- wr_pd  in  WIDTH  producer data.
- rd_pvld  out  1  consumer valid.
- rd_prdy  in  1  consumer ready.
- rd_pd  out  WIDTH  consumer data.
- ram_we  out  1  RAM write enable.
- ram_wa  out  AW  RAM write address.
- ram_di  out  WIDTH  RAM write data.
- ram_re  out  1  RAM read-address latch enable.
- ram_ra  out  AW  RAM read address.
- ram_ore  out  1  RAM output-register enable.
- ram_dout  in  WIDTH  RAM registered read data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (sampled high at posedge):
  - wr_ptr, rd_ptr, occ, avail, s1_vld, s2_vld, skid count and skid pointers all go to 0.
  - rd_pvld=0, ram_re=0, ram_ore=0, ram_we=0, ram_wa=0, ram_ra=0.
  - wr_prdy is forced 0 while rst=1.
  - A reset mid-operation discards all stored and in-flight data; no RAM clear is needed.
- Write side:
  - wr_prdy = !rst && occ<DEPTH.
  - ram_we = wr_pvld && wr_prdy.
  - ram_wa = wr_ptr; ram_di = wr_pd (both combinational).
  - On accept, wr_ptr advances, wrapping 60->0 (explicit compare, not a power-of-two mask).
- Counters:
  - avail = entries written but not yet read-issued (0..61).
  - occ = entries written but not yet captured into skid (0..61).
  - A write and a release in the same cycle leave the count unchanged.
- Read issue:
  - used = s1_vld + s2_vld + skid_cnt.
  - pop = rd_pvld && rd_prdy.
  - ram_re = avail>0 && (used - pop) < OUT_DEPTH; ram_ra = rd_ptr.
  - On issue, rd_ptr advances (wraps 60->0) and avail decrements.
- Pipeline:
  - Cycle t: ram_re.
  - Cycle t+1: s1_vld=1, and ram_ore = s1_vld.
  - Cycle t+2: s2_vld=1; ram_dout is valid and is pushed into skid; occ decrements (slot released).
- Slot release timing: a RAM slot is released only after capture, so a write can never alias an address still being read.
- Skid buffer:
  - OUT_DEPTH-entry circular buffer.
  - rd_pvld = skid_cnt>0; rd_pd = skid head, driven from a register.
  - Pop on rd_pvld && rd_prdy.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by the issue rule.
- Latency: a word written at cycle t into an empty FIFO is first visible on rd_pvld at t+4 (write commit, re, ore, capture).
- Throughput: 1 word/cycle sustained with rd_prdy held high.
- Total capacity = DEPTH + OUT_DEPTH = 64 words.
- Boundaries:
  - occ==61: wr_prdy=0.
  - avail==0: no issue.
  - rd_prdy low: in-flight words still land in skid; issue stalls at used==OUT_DEPTH.

Optional Feature:
- Macro: NV_RAM_FIFO_CTRL_HWM_EN.
- Defined:
  - Adds output hwm [6:0], the high-water mark of total words held (occ+skid_cnt).
  - hwm updates each cycle to max(hwm, current) and resets to 0.
  - Adds input hwm_clr [1]: sync clear, taking priority over update.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: DEPTH/WIDTH/AW constants and a ptr_inc wrap function (n==DEPTH-1 ? 0 : n+1).
- One natural sub-module: nv_ram_fifo_ctrl_skid (OUT_DEPTH x WIDTH push/pop buffer with count).

Test Plan:
- Reset then idle -> rd_pvld=0, wr_prdy=1, ram_re=0, ram_ore=0.
- Single word 0xA5A5_0000_0000_0001 written at cycle 10, rd_prdy=1 -> rd_pvld first high at cycle 14 with that data; ram_wa=0, ram_ra=0.
- rd_prdy=0, write 70 words -> exactly 64 accepted; wr_prdy=0 after the 64th; ram_re stops with 3 words held in pipeline/skid.
- Continuous write+read of 200 incrementing words, rd_prdy=1 -> 1 word/cycle out, in order; pointers wrap 60->0 with no loss or duplication.
- Random rd_prdy (50%) with simultaneous write/read at occ=61 -> no overflow, no data loss; occ unchanged when a write and a release coincide.
- Reset asserted while 20 words are stored and 2 are in flight -> next cycle rd_pvld=0; occ=0; subsequent writes read back correctly from address 0.
